// File: rtl/fcpu_pkg.sv
// Shared CPU-wide widths and the reorder-buffer station record.
package fcpu_pkg;

  localparam int unsigned N_ROB_W    = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RSV_ID_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned CDB_W      = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [INSTR_W-1:0]    opcode;
    logic [DATA_W-1:0]     content;
    logic [RSV_ID_W-1:0]   station_id;
  } station_t;

  typedef enum logic [1:0] {
    ENT_HOLD,
    ENT_RESERVE,
    ENT_CDB,
    ENT_CLEAR
  } ent_op_e;

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: reserve / result-capture / clear update and its register.
module rob_entry
  import fcpu_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  reserve,
  input  logic                  no_wait,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic [INSTR_W-1:0]    opcode,
  input  logic                  cdb_wr,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic                  clear,
  output station_t              entry
);

  station_t entry_q, entry_d;
  ent_op_e  op;

  // Clear (retire or squash) beats everything so squashed slots drop late results.
  always_comb begin
    op = ENT_HOLD;
    if (clear)                        op = ENT_CLEAR;
    else if (reserve)                 op = ENT_RESERVE;
    else if (cdb_wr && entry_q.valid) op = ENT_CDB;
  end

  always_comb begin
    entry_d = entry_q;
    case (op)
      ENT_CLEAR: entry_d = '0;
      ENT_RESERVE: begin
        entry_d.valid      = 1'b1;
        entry_d.ready      = no_wait;
        entry_d.dst_reg    = dst_reg;
        entry_d.opcode     = opcode;
        entry_d.content    = '0;
        entry_d.station_id = RSV_ID_W'(IDX);
      end
      ENT_CDB: begin
        entry_d.ready   = 1'b1;
        entry_d.content = cdb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer with CDB capture, operand read ports and flush.
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB results onto the read ports.
module reorder_buffer_mc
  import fcpu_pkg::*;
#(
  parameter int unsigned DEPTH_W    = N_ROB_W,
  parameter int unsigned ROB_PORT_W = 6,
  parameter int unsigned CDB_N      = 2,
  parameter int unsigned COMMIT_W   = 2
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        i_valid,
  output logic                                        i_ready,
  output logic [RSV_ID_W-1:0]                         i_rsv_id,
  input  logic [REG_ADDR_W-1:0]                       i_dst_reg,
  input  logic                                        i_no_wait,
  input  logic [INSTR_W-1:0]                          i_opcode,
  input  logic [ROB_PORT_W-1:0][RSV_ID_W-1:0]         rob_id,
  output logic [ROB_PORT_W-1:0][RSV_ID_W+DATA_W-1:0]  rob_data,
  output logic [ROB_PORT_W-1:0]                       rob_data_filled,
  output logic [COMMIT_W-1:0]                         o_valid,
  output station_t [COMMIT_W-1:0]                     o_commit_data,
  input  logic [COMMIT_W-1:0]                         o_ready,
  input  logic [CDB_N-1:0]                            cdb_valid,
  input  logic [CDB_N-1:0][CDB_W-1:0]                 cdb,
  input  logic                                        flush_valid,
  input  logic [RSV_ID_W-1:0]                         flush_id,
  output logic [DEPTH_W:0]                            o_count
);

  localparam int unsigned      DEPTH     = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] CNT_ONE   = (DEPTH_W+1)'(1);

  typedef logic [DEPTH_W-1:0] ptr_t;

  ptr_t             head_q, head_d, tail_q, tail_d;
  logic [DEPTH_W:0] count_q, count_d;

  station_t          entries [DEPTH];
  logic [DEPTH-1:0]  reserve, cdb_wr, clear_ret, squash;
  logic [DATA_W-1:0] cdb_sel [DEPTH];
  logic [DEPTH_W:0]  retire_cnt;
  logic              alloc;
  ptr_t              fid_p, squash_len, surv_p;

  assign fid_p    = flush_id[DEPTH_W-1:0];
  assign i_ready  = (count_q != DEPTH_CNT) && !flush_valid;
  assign i_rsv_id = RSV_ID_W'(tail_q);
  assign alloc    = i_valid && i_ready;
  assign o_count  = count_q;

  // Ascending lane order lets the higher-numbered lane win a collision.
  always_comb begin
    cdb_wr = '0;
    for (int unsigned e = 0; e < DEPTH; e++) cdb_sel[e] = '0;
    for (int unsigned l = 0; l < CDB_N; l++) begin
      if (cdb_valid[l]) begin
        cdb_wr[cdb[l][DATA_W +: DEPTH_W]]  = 1'b1;
        cdb_sel[cdb[l][DATA_W +: DEPTH_W]] = cdb[l][DATA_W-1:0];
      end
    end
  end

  always_comb begin
    logic vprefix, rprefix;
    ptr_t idx;
    vprefix       = 1'b1;
    rprefix       = 1'b1;
    o_valid       = '0;
    o_commit_data = '0;
    clear_ret     = '0;
    retire_cnt    = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      idx              = head_q + ptr_t'(k);
      o_commit_data[k] = entries[idx];
      vprefix          = vprefix && entries[idx].valid && entries[idx].ready;
      o_valid[k]       = vprefix;
      rprefix          = rprefix && vprefix && o_ready[k];
      if (rprefix) begin
        clear_ret[idx] = 1'b1;
        retire_cnt     = retire_cnt + CNT_ONE;
      end
    end
  end

  // Squash span is flush_id+1 .. tail-1; an empty span makes the flush a no-op.
  assign squash_len = tail_q - fid_p - ptr_t'(1);
  assign surv_p     = fid_p + ptr_t'(1) - head_q;

  always_comb begin
    ptr_t off;
    squash = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      off       = ptr_t'(e) - fid_p - ptr_t'(1);
      squash[e] = flush_valid && (off < squash_len);
    end
  end

  always_comb begin
    reserve         = '0;
    reserve[tail_q] = alloc;
    head_d          = head_q + retire_cnt[DEPTH_W-1:0];
    if (flush_valid) begin
      tail_d = fid_p + ptr_t'(1);
      // A no-op flush keeps the live count, which also covers a full buffer.
      if (squash_len == '0) count_d = count_q - retire_cnt;
      else                  count_d = {1'b0, surv_p} - retire_cnt;
    end else begin
      tail_d  = tail_q + ptr_t'(alloc);
      count_d = count_q + (DEPTH_W+1)'(alloc) - retire_cnt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    rob_entry #(.IDX(e)) u_entry (
      .clk      (clk),
      .nrst     (nrst),
      .reserve  (reserve[e]),
      .no_wait  (i_no_wait),
      .dst_reg  (i_dst_reg),
      .opcode   (i_opcode),
      .cdb_wr   (cdb_wr[e]),
      .cdb_data (cdb_sel[e]),
      .clear    (clear_ret[e] || squash[e]),
      .entry    (entries[e])
    );
  end

  always_comb begin
    ptr_t              ridx;
    logic [DATA_W-1:0] rcontent;
    logic              rfilled;
    rob_data        = '0;
    rob_data_filled = '0;
    for (int unsigned p = 0; p < ROB_PORT_W; p++) begin
      ridx     = rob_id[p][DEPTH_W-1:0];
      rcontent = entries[ridx].content;
      rfilled  = entries[ridx].ready;
`ifdef ROB_CDB_BYPASS_EN
      for (int unsigned l = 0; l < CDB_N; l++) begin
        if (cdb_valid[l] && (cdb[l][DATA_W +: DEPTH_W] == ridx) && entries[ridx].valid) begin
          rcontent = cdb[l][DATA_W-1:0];
          rfilled  = 1'b1;
        end
      end
`endif
      rob_data[p]        = {rob_id[p], rcontent};
      rob_data_filled[p] = rfilled;
    end
  end

endmodule

// File: doc/reorder_buffer_mc.md
REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 SHALL have parameter DEPTH_W, default 4, log2 of entry count (DEPTH = 2**DEPTH_W).
REQ-002 SHALL have parameter ROB_PORT_W, default 6, number of operand read ports.
REQ-003 SHALL have parameter CDB_N, default 2, number of result broadcast buses.
REQ-004 SHALL have parameter COMMIT_W, default 2, maximum retirements per cycle (1..DEPTH).
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk input 1 system clock; nrst input 1 asynchronous active-low reset.
REQ-006 SHALL have these dispatch ports: i_valid input 1; i_ready output 1; i_rsv_id output RSV_ID_W (allocated entry id); i_dst_reg input REG_ADDR_W; i_no_wait input 1 (entry ready at allocation); i_opcode input INSTR_W.
REQ-007 SHALL have these read ports: rob_id input ROB_PORT_W x RSV_ID_W; rob_data output ROB_PORT_W x (RSV_ID_W+DATA_W) ({id, content}); rob_data_filled output ROB_PORT_W.
REQ-008 SHALL have these commit ports: o_valid output COMMIT_W; o_commit_data output COMMIT_W x station_t; o_ready input COMMIT_W.
REQ-009 SHALL have these broadcast ports: cdb_valid input CDB_N; cdb input CDB_N x CDB_W ({id, data}, id at [DATA_W+:RSV_ID_W]).
REQ-010 SHALL have these flush ports: flush_valid input 1; flush_id input RSV_ID_W (last surviving entry).
REQ-011 SHALL have this status port: o_count output DEPTH_W+1 (occupied entries).

Function
REQ-012 SHALL hold head, tail (DEPTH_W bits, modulo-DEPTH wrap) and count (DEPTH_W+1 bits); full is count==DEPTH, empty is count==0.
REQ-013 SHALL drive i_ready = !full && !flush_valid, independent of same-cycle commits; i_rsv_id = tail.
REQ-014 SHALL, on i_valid&&i_ready, write the tail entry next edge: valid=1, ready=i_no_wait, dst_reg, opcode, content=0, station_id=index; tail+1.
REQ-015 SHALL, for each cdb lane with cdb_valid set, next edge set ready=1 and content=data in the addressed entry only if it is valid; writes to invalid entries are ignored.
REQ-016 SHALL give the higher-numbered lane priority when two cdb lanes hit the same entry in one cycle.
REQ-017 SHALL drive o_valid[k] = entry(head+k) valid && ready && o_valid[k-1] (in-order prefix); o_commit_data[k] = entry(head+k).
REQ-018 SHALL retire lane k iff o_valid[j]&&o_ready[j] for all j<=k; retired entries are cleared to zero and head advances by the retire count, with wrap.
REQ-019 SHALL, on flush_valid, clear all valid entries strictly younger than flush_id (flush_id+1 .. tail-1, modulo) and set tail=flush_id+1; flush_id==tail-1 is a no-op.
REQ-020 SHALL, when commit and flush coincide, perform both, with next count = (flush_id+1-head) mod DEPTH minus the retire count, and next count = DEPTH when a full buffer is flushed at flush_id==tail-1.
REQ-021 SHALL ignore cdb writes to entries squashed in the same cycle.
REQ-022 SHALL update count as count + alloc - retire when no flush occurs; simultaneous alloc and retire in a full buffer are impossible (i_ready low).
REQ-023 SHALL return on rob_data the registered entry {rob_id, content} combinationally (no latch), and on rob_data_filled the registered ready bit.

Reset
REQ-024 SHALL, on nrst low, asynchronously clear every entry, head, tail and count; i_ready=1, o_valid=0, o_count=0, rob_data_filled=0; reset mid-flush or mid-commit discards all state.

Configuration
REQ-025 SHALL, with ROB_CDB_BYPASS_EN defined, forward same-cycle cdb data into rob_data and rob_data_filled when the cdb id matches rob_id and the entry is valid; without the macro, reads see only registered state (one-cycle visibility lag).

Structure
REQ-026 SHALL take station_t, DATA_W, RSV_ID_W, REG_ADDR_W, INSTR_W and CDB_W from fcpu_pkg; DEPTH_W default SHALL be tied to N_ROB_W there, and RSV_ID_W SHALL be at least DEPTH_W.
REQ-027 SHALL put the per-entry update (reserve/cdb/release/clear mux and register) in sub-module rob_entry, instantiated DEPTH times.

Verification
REQ-028 SHALL cover fill: 16 dispatches with i_no_wait=0 -> i_ready=0 after the 16th, o_count=16, i_rsv_id wraps to 0.
REQ-029 SHALL cover dual commit: ids 3,4 filled via cdb, o_ready=2'b11 -> both retire in one cycle, head +2, o_count -2.
REQ-030 SHALL cover a blocked prefix: id 3 not ready, id 4 ready -> o_valid=2'b00, no retire.
REQ-031 SHALL cover flush: tail=9, flush_id=5 -> entries 6..8 cleared, next i_rsv_id=6, and a cdb write to id 7 in the same cycle is ignored.
REQ-032 SHALL cover a cdb collision: both lanes target id 2 with data A and B -> content=B, ready=1.
REQ-033 SHALL cover bypass: cdb id 5 with data 0x55 while rob_id[0]=5 -> rob_data_filled[0]=1 in the same cycle with the macro defined, and in the next cycle without it.
